// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM state encoding, the requester port ids and the default memory depth.
// Imported by mem_arbiter and rr_arb2.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Port ids double as bit positions in the arbiter request/grant vectors.
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam int MEM_DEPTH_DEF = 1024;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports: req[1:0] (bit0 fetch, bit1 data), last = port that won the previous tie,
//        grant[1:0] one-hot (all zero when nothing is requested).
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie the port that did not win the previous tie goes first.
            2'b11:   grant = (last == PORT_FETCH) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port data memory between instruction fetch (read-only) and the
// data/stack port (read/write): IDLE grants, ACCESS drives the memory for one cycle
// (memory acts on that cycle's negedge), DONE pulses the winner's ack. Ack arrives two
// posedges after the request is first seen.
// Ports: clk/rst (sync, active-high); if_* fetch port; d_* data port; mem_* memory
// port; busy is high whenever the FSM is not in IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err,

    output logic              busy
);

    state_t            state_q,     state_d;
    logic              rr_last_q,   rr_last_d;
    logic              port_q,      port_d;
    logic              we_q,        we_d;
    logic              err_pre_q,   err_pre_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q,    mem_we_d;
    logic              if_ack_q,    if_ack_d;
    logic              if_err_q,    if_err_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic              d_ack_q,     d_ack_d;
    logic              d_err_q,     d_err_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

    logic [1:0]        req_vec;
    logic [1:0]        grant;
    logic              sel_data;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic              sel_bad;
    logic              acc_err;

    assign req_vec = {d_req, if_req};

    rr_arb2 u_rr_arb2 (
        .req   (req_vec),
        .last  (rr_last_q),
        .grant (grant)
    );

    assign sel_data = grant[1];
    assign sel_addr = sel_data ? d_addr : if_addr;
    assign sel_we   = sel_data & d_we;   // fetch is read-only
    assign sel_bad  = (sel_addr == '0) || (sel_addr >= ADDR_W'(MEM_DEPTH));
    assign acc_err  = err_pre_q | mem_err;

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        port_d      = port_q;
        we_d        = we_q;
        err_pre_d   = err_pre_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if_ack_d    = 1'b0;
        if_err_d    = if_err_q;
        if_rdata_d  = if_rdata_q;
        d_ack_d     = 1'b0;
        d_err_d     = d_err_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    state_d     = ACCESS;
                    port_d      = sel_data ? PORT_DATA : PORT_FETCH;
                    we_d        = sel_we;
                    err_pre_d   = sel_bad;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_data ? d_wdata : '0;
                    // A bad address never reaches the memory as a write.
                    mem_we_d    = sel_we & ~sel_bad;
                    if (req_vec == 2'b11) begin
                        rr_last_d = sel_data ? PORT_DATA : PORT_FETCH;
                    end
                end
            end

            ACCESS: begin
                state_d = DONE;
                if (port_q == PORT_DATA) begin
                    d_ack_d = 1'b1;
                    d_err_d = acc_err;
                    if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else begin
                    if_ack_d   = 1'b1;
                    if_err_d   = acc_err;
                    if_rdata_d = mem_rdata;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_last_q   <= PORT_FETCH;
            port_q      <= PORT_FETCH;
            we_q        <= 1'b0;
            err_pre_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            port_q      <= port_d;
            we_q        <= we_d;
            err_pre_q   <= err_pre_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign if_ack    = if_ack_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_ack;
    logic [63:0] if_rdata;
    logic        if_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic        d_err;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_err = 1'b0;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] ram [0:1023];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .busy      (busy)
    );

    // Negedge-sampled single-port memory; the read returns the pre-write contents.
    always @(negedge clk) begin
        if (mem_we) begin
            ram[mem_addr[9:0]] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr[9:0]];
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Raises one request, waits (bounded) for its ack, drops the request in the ack cycle.
    task automatic run_access(input bit is_d, input bit we, input logic [63:0] addr,
                              input logic [63:0] wdata, output int lat, output int we_cnt);
        lat    = -1;
        we_cnt = 0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (mem_we) we_cnt++;
            if ((is_d && d_ack) || (!is_d && if_ack)) begin
                lat = c;
                break;
            end
        end
        if (is_d) d_req = 1'b0;
        else      if_req = 1'b0;
    endtask

    // Both ports request in the same cycle; returns the cycle index of each ack.
    task automatic run_tie(output int d_cyc, output int f_cyc);
        d_cyc = -1;
        f_cyc = -1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'd5;
        if_req = 1'b1; if_addr = 64'd5;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (d_ack) begin
                if (d_cyc < 0) d_cyc = c;
                d_req = 1'b0;
            end
            if (if_ack) begin
                if (f_cyc < 0) f_cyc = c;
                if_req = 1'b0;
            end
            if (!d_req && !if_req) break;
        end
        d_req  = 1'b0;
        if_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wc, dc, fc, acks;

        // Reset state
        do_reset();
        check_val("rst_busy",     64'(busy),   64'd0);
        check_val("rst_acks",     64'({if_ack, d_ack}), 64'd0);
        check_val("rst_errs",     64'({if_err, d_err}), 64'd0);
        check_val("rst_mem_we",   64'(mem_we), 64'd0);
        check_val("rst_mem_addr", mem_addr,    64'd0);
        check_val("rst_mem_wdat", mem_wdata,   64'd0);
        check_val("rst_if_rdata", if_rdata,    64'd0);
        check_val("rst_d_rdata",  d_rdata,     64'd0);

        // 1: data write to address 5
        run_access(1'b1, 1'b1, 64'd5, 64'hDEAD_BEEF, lat, wc);
        check_val("t1_latency", 64'(lat), 64'd2);
        check_val("t1_d_err",   64'(d_err), 64'd0);
        check_val("t1_we_cnt",  64'(wc), 64'd1);
        check_val("t1_if_ack",  64'(if_ack), 64'd0);
        tick();
        check_val("t1_idle_we", 64'(mem_we), 64'd0);

        // 2: fetch reads it back
        run_access(1'b0, 1'b0, 64'd5, 64'd0, lat, wc);
        check_val("t2_latency", 64'(lat), 64'd2);
        check_val("t2_rdata",   if_rdata, 64'hDEAD_BEEF);
        check_val("t2_if_err",  64'(if_err), 64'd0);
        check_val("t2_we_cnt",  64'(wc), 64'd0);
        tick();

        // 3: ties after reset - data first, then fetch on the repeat
        do_reset();
        run_tie(dc, fc);
        check_val("t3a_d_cyc", 64'(dc), 64'd2);
        check_val("t3a_f_cyc", 64'(fc), 64'd5);
        check_val("t3a_d_rdata", d_rdata, 64'hDEAD_BEEF);
        tick();
        run_tie(dc, fc);
        check_val("t3b_f_cyc", 64'(fc), 64'd2);
        check_val("t3b_d_cyc", 64'(dc), 64'd5);
        tick();

        // 4: out-of-range writes
        run_access(1'b1, 1'b1, 64'd0, 64'h1111, lat, wc);
        check_val("t4a_latency", 64'(lat), 64'd2);
        check_val("t4a_d_err",   64'(d_err), 64'd1);
        check_val("t4a_we_cnt",  64'(wc), 64'd0);
        check_val("t4a_rdata_hold", d_rdata, 64'hDEAD_BEEF);
        tick();
        run_access(1'b1, 1'b1, 64'd1024, 64'h2222, lat, wc);
        check_val("t4b_latency", 64'(lat), 64'd2);
        check_val("t4b_d_err",   64'(d_err), 64'd1);
        check_val("t4b_we_cnt",  64'(wc), 64'd0);
        tick();
        run_access(1'b0, 1'b0, 64'd5, 64'd0, lat, wc);
        check_val("t4c_rdata", if_rdata, 64'hDEAD_BEEF);
        check_val("t4c_if_err", 64'(if_err), 64'd0);
        tick();

        // 5: reset during ACCESS of a write
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'd7; d_wdata = 64'h1234;
        tick();
        check_val("t5_busy_acc", 64'(busy), 64'd1);
        check_val("t5_we_acc",   64'(mem_we), 64'd1);
        rst = 1'b1;
        tick();
        check_val("t5_busy_rst", 64'(busy), 64'd0);
        check_val("t5_we_rst",   64'(mem_we), 64'd0);
        check_val("t5_addr_rst", mem_addr, 64'd0);
        rst = 1'b0;
        d_req = 1'b0;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (d_ack) acks++;
        end
        check_val("t5_no_ack", 64'(acks), 64'd0);
        run_access(1'b1, 1'b0, 64'd5, 64'd0, lat, wc);
        check_val("t5_after_lat",   64'(lat), 64'd2);
        check_val("t5_after_rdata", d_rdata, 64'hDEAD_BEEF);
        check_val("t5_if_untouched", if_rdata, 64'd0);
        tick();

        // 6: request dropped one cycle after grant
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'd5;
        tick();
        check_val("t6_busy_grant", 64'(busy), 64'd1);
        d_req = 1'b0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (d_ack) acks++;
        end
        check_val("t6_ack_once", 64'(acks), 64'd1);
        check_val("t6_busy_end", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
